regs_read_stage: RTL

REGS_READ_STAGE -- requirements
Module: regs_read_stage

---
 rtl/regs_read_stage_if.sv | 40 ++++
 rtl/regs_read_stage.sv | 104 ++++++++++
 2 files changed

// File: rtl/regs_read_stage_if.sv
// Operand-fetch stage bundle: request side, write-back port, register-file
// control/data and operand output with bypass counter.
interface regs_read_stage_if;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  rno0;
  logic [3:0]  rno1;
  logic [3:0]  rno2;
  logic        wb_wr;
  logic [3:0]  wb_rno;
  logic [31:0] wb_din;
  logic        rf_wr;
  logic [3:0]  rf_rno0;
  logic [3:0]  rf_rno1;
  logic [3:0]  rf_rno2;
  logic [31:0] rf_din;
  logic [31:0] rf_dout0;
  logic [31:0] rf_dout1;
  logic [31:0] rf_dout2;
  logic        op_valid;
  logic        op_ready;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] op_c;
  logic [15:0] byp_cnt;

  modport master (
    output req_valid, rno0, rno1, rno2, wb_wr, wb_rno, wb_din,
           rf_dout0, rf_dout1, rf_dout2, op_ready,
    input  req_ready, rf_wr, rf_rno0, rf_rno1, rf_rno2, rf_din,
           op_valid, op_a, op_b, op_c, byp_cnt
  );

  modport slave (
    input  req_valid, rno0, rno1, rno2, wb_wr, wb_rno, wb_din,
           rf_dout0, rf_dout1, rf_dout2, op_ready,
    output req_ready, rf_wr, rf_rno0, rf_rno1, rf_rno2, rf_din,
           op_valid, op_a, op_b, op_c, byp_cnt
  );
endinterface

// File: rtl/regs_read_stage.sv
// Register read stage with write-back bypass: accept -> operands valid 2 cycles later.
// Write-back stalls acceptance; held operands track writes to their registers.
module regs_read_stage (
  input  logic           clk,
  input  logic           rst_n,
  regs_read_stage_if.slave bus
);

  typedef enum logic [1:0] {EMPTY, FETCH, VALID} state_t;

  state_t      state_q;
  logic        op_valid_q;
  logic [3:0]  rno0_q, rno1_q, rno2_q;
  logic [31:0] op_a_q, op_b_q, op_c_q;
  logic [31:0] op_a_d, op_b_d, op_c_d;
  logic [15:0] byp_cnt_q, byp_cnt_d;
  logic        accept;
  logic        hit0, hit1, hit2, any_hit;

  // The register file shares port 0 between the write and the first read.
  assign bus.rf_wr   = bus.wb_wr;
  assign bus.rf_din  = bus.wb_din;
  assign bus.rf_rno0 = bus.wb_wr ? bus.wb_rno : bus.rno0;
  assign bus.rf_rno1 = bus.rno1;
  assign bus.rf_rno2 = bus.rno2;

  assign bus.req_ready = !bus.wb_wr &&
                         ((state_q == EMPTY) || ((state_q == VALID) && bus.op_ready));
  assign accept = bus.req_valid && bus.req_ready;

  assign hit0 = bus.wb_wr && (bus.wb_rno == rno0_q);
  assign hit1 = bus.wb_wr && (bus.wb_rno == rno1_q);
  assign hit2 = bus.wb_wr && (bus.wb_rno == rno2_q);
  // Accept and write-back are mutually exclusive, so a hit here is never pre-empted.
  assign any_hit = ((state_q == FETCH) || (state_q == VALID)) && (hit0 || hit1 || hit2);

  assign op_a_d = hit0 ? bus.wb_din : ((state_q == FETCH) ? bus.rf_dout0 : op_a_q);
  assign op_b_d = hit1 ? bus.wb_din : ((state_q == FETCH) ? bus.rf_dout1 : op_b_q);
  assign op_c_d = hit2 ? bus.wb_din : ((state_q == FETCH) ? bus.rf_dout2 : op_c_q);

  assign byp_cnt_d = (any_hit && (byp_cnt_q != 16'hFFFF)) ? byp_cnt_q + 16'd1 : byp_cnt_q;

  assign bus.op_valid = op_valid_q;
  assign bus.op_a     = op_a_q;
  assign bus.op_b     = op_b_q;
  assign bus.op_c     = op_c_q;
  assign bus.byp_cnt  = byp_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      op_valid_q <= 1'b0;
      rno0_q     <= 4'd0;
      rno1_q     <= 4'd0;
      rno2_q     <= 4'd0;
      op_a_q     <= 32'd0;
      op_b_q     <= 32'd0;
      op_c_q     <= 32'd0;
      byp_cnt_q  <= 16'd0;
    end else begin
      byp_cnt_q <= byp_cnt_d;
      case (state_q)
        EMPTY: begin
          op_valid_q <= 1'b0;
          if (accept) begin
            rno0_q  <= bus.rno0;
            rno1_q  <= bus.rno1;
            rno2_q  <= bus.rno2;
            state_q <= FETCH;
          end
        end
        FETCH: begin
          op_a_q     <= op_a_d;
          op_b_q     <= op_b_d;
          op_c_q     <= op_c_d;
          op_valid_q <= 1'b1;
          state_q    <= VALID;
        end
        VALID: begin
          if (accept) begin
            rno0_q     <= bus.rno0;
            rno1_q     <= bus.rno1;
            rno2_q     <= bus.rno2;
            op_valid_q <= 1'b0;
            state_q    <= FETCH;
          end else begin
            op_a_q <= op_a_d;
            op_b_q <= op_b_d;
            op_c_q <= op_c_d;
            if (bus.op_ready) begin
              op_valid_q <= 1'b0;
              state_q    <= EMPTY;
            end
          end
        end
        default: begin
          op_valid_q <= 1'b0;
          state_q    <= EMPTY;
        end
      endcase
    end
  end

endmodule
